// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Merges load-use hazards, a self-sequenced multi-cycle HI/LO mult/div unit
// and ID-stage branch resolution into the PC / IF-ID / ID-EX control signals,
// and keeps a saturating count of stalled cycles.
module pipeline_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lw_hazard,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             id_md_op,
    input  logic             id_reads_hilo,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Mux_Select_Stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // Remaining busy cycles of the mult/div unit; zero means idle.
    logic [5:0] md_cnt;
    logic       stall;

    assign md_busy = (md_cnt != '0);
    assign md_done = (md_cnt == 6'd1);

    // Sequence the mult/div unit: load on start when idle, count down when busy.
    // A start arriving while busy is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 6'd1;
        end else if (md_start) begin
            md_cnt <= md_is_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        end
    end

    // Combine the stall sources and derive the pipeline controls; reset forces
    // a frozen front end with a bubble into ID/EX.
    always_comb begin
        stall            = lw_hazard | (md_busy & id_reads_hilo) | (md_busy & id_md_op);
        PCWrite          = rst_n & ~stall;
        IF_ID_Write      = rst_n & ~stall;
        Mux_Select_Stall = ~rst_n | stall;
        IF_ID_Flush      = rst_n & branch_taken & ~stall;
    end

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the stimulus process pushes the
// hand-computed expected values for each cycle, the monitor pops and compares
// them on the falling edge of that same cycle.
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lw_hazard;
    logic        md_start;
    logic        md_is_div;
    logic        id_md_op;
    logic        id_reads_hilo;
    logic        branch_taken;

    logic        PCWrite, IF_ID_Write, IF_ID_Flush, Mux_Select_Stall, md_busy, md_done;
    logic [15:0] stall_cycles;
    logic        PCWrite4, IF_ID_Write4, IF_ID_Flush4, Mux_Select_Stall4, md_busy4, md_done4;
    logic [3:0]  stall_cycles4;

    pipeline_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .lw_hazard(lw_hazard), .md_start(md_start),
        .md_is_div(md_is_div), .id_md_op(id_md_op), .id_reads_hilo(id_reads_hilo),
        .branch_taken(branch_taken), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .Mux_Select_Stall(Mux_Select_Stall),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    pipeline_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .lw_hazard(lw_hazard), .md_start(md_start),
        .md_is_div(md_is_div), .id_md_op(id_md_op), .id_reads_hilo(id_reads_hilo),
        .branch_taken(branch_taken), .PCWrite(PCWrite4), .IF_ID_Write(IF_ID_Write4),
        .IF_ID_Flush(IF_ID_Flush4), .Mux_Select_Stall(Mux_Select_Stall4),
        .md_busy(md_busy4), .md_done(md_done4), .stall_cycles(stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index; the cycle starts at a rising edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       name;
        int unsigned sig;
        logic [31:0] exp;
    } exp_t;

    localparam int unsigned S_PCW = 0, S_IFW = 1, S_FLUSH = 2, S_MUX = 3,
                            S_BUSY = 4, S_DONE = 5, S_CNT = 6, S_CNT4 = 7;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic logic [31:0] actual(int unsigned sig);
        case (sig)
            S_PCW:   return {31'd0, PCWrite};
            S_IFW:   return {31'd0, IF_ID_Write};
            S_FLUSH: return {31'd0, IF_ID_Flush};
            S_MUX:   return {31'd0, Mux_Select_Stall};
            S_BUSY:  return {31'd0, md_busy};
            S_DONE:  return {31'd0, md_done};
            S_CNT:   return {16'd0, stall_cycles};
            default: return {28'd0, stall_cycles4};
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
            end else begin
                a = actual(e.sig);
                if (a !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got %0d, expected %0d", e.name, cyc, a, e.exp);
                end
            end
        end
    end

    task automatic expect_sig(input string name, input int unsigned sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.name = name; e.sig = sig; e.exp = v;
        sb.push_back(e);
    endtask

    // Control outputs for a given stall / flush expectation.
    task automatic expect_ctrl(input string name, input logic stalled, input logic flush);
        expect_sig({name, ".PCWrite"}, S_PCW, {31'd0, ~stalled});
        expect_sig({name, ".IF_ID_Write"}, S_IFW, {31'd0, ~stalled});
        expect_sig({name, ".Mux_Select_Stall"}, S_MUX, {31'd0, stalled});
        expect_sig({name, ".IF_ID_Flush"}, S_FLUSH, {31'd0, flush});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lw, input logic st, input logic dv,
                         input logic mdop, input logic hilo, input logic br);
        lw_hazard = lw; md_start = st; md_is_div = dv;
        id_md_op = mdop; id_reads_hilo = hilo; branch_taken = br;
    endtask

    task automatic do_reset(input string name);
        next_cycle();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        expect_ctrl({name, ".rst"}, 1'b1, 1'b0);
        expect_sig({name, ".rst.busy"}, S_BUSY, 0);
        expect_sig({name, ".rst.cnt"}, S_CNT, 0);
        next_cycle();
        rst_n = 1'b1;
        expect_ctrl({name, ".rel"}, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1);

        // Reset held with a taken branch pending: still no flush.
        next_cycle();
        expect_ctrl("reset", 1'b1, 1'b0);
        expect_sig("reset.cnt", S_CNT, 0);
        expect_sig("reset.busy", S_BUSY, 0);
        expect_sig("reset.done", S_DONE, 0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        expect_ctrl("release", 1'b0, 1'b0);

        // Single-cycle load-use hazard.
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        expect_ctrl("lw", 1'b1, 1'b0);
        expect_sig("lw.cnt0", S_CNT, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        expect_ctrl("lw.after", 1'b0, 1'b0);
        expect_sig("lw.cnt1", S_CNT, 1);

        // Multiply followed by mfhi.
        do_reset("pre_mult");
        next_cycle();
        drive(0, 1, 0, 0, 0, 0);
        expect_ctrl("mult.c0", 1'b0, 1'b0);
        expect_sig("mult.c0.busy", S_BUSY, 0);
        for (int unsigned i = 1; i <= 4; i++) begin
            next_cycle();
            drive(0, 0, 0, 0, 1, 0);
            expect_ctrl($sformatf("mult.c%0d", i), 1'b1, 1'b0);
            expect_sig($sformatf("mult.c%0d.busy", i), S_BUSY, 1);
            expect_sig($sformatf("mult.c%0d.done", i), S_DONE, (i == 4) ? 1 : 0);
        end
        next_cycle();
        expect_ctrl("mult.c5", 1'b0, 1'b0);
        expect_sig("mult.c5.busy", S_BUSY, 0);
        expect_sig("mult.c5.done", S_DONE, 0);
        expect_sig("mult.cnt", S_CNT, 4);

        // Divide with ID mult/div op held, re-pulsed start at cycle 10.
        do_reset("pre_div");
        next_cycle();
        drive(0, 1, 1, 0, 0, 0);
        expect_ctrl("div.c0", 1'b0, 1'b0);
        for (int unsigned i = 1; i <= 32; i++) begin
            next_cycle();
            drive(0, (i == 10) ? 1'b1 : 1'b0, 1'b0, 1, 0, 0);
            expect_ctrl($sformatf("div.c%0d", i), 1'b1, 1'b0);
            expect_sig($sformatf("div.c%0d.busy", i), S_BUSY, 1);
            expect_sig($sformatf("div.c%0d.done", i), S_DONE, (i == 32) ? 1 : 0);
        end
        next_cycle();
        expect_ctrl("div.c33", 1'b0, 1'b0);
        expect_sig("div.c33.busy", S_BUSY, 0);
        expect_sig("div.c33.done", S_DONE, 0);
        expect_sig("div.cnt", S_CNT, 32);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);

        // Branch against a stall, then unstalled.
        next_cycle();
        drive(1, 0, 0, 0, 0, 1);
        expect_ctrl("br.stalled", 1'b1, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        expect_ctrl("br.free", 1'b0, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        expect_ctrl("br.none", 1'b0, 1'b0);

        // Reset in busy cycle 7 of a divide abandons it.
        next_cycle();
        drive(0, 1, 1, 0, 0, 0);
        for (int unsigned i = 1; i <= 6; i++) begin
            next_cycle();
            drive(0, 0, 0, 0, 0, 0);
            expect_sig($sformatf("abort.c%0d.busy", i), S_BUSY, 1);
        end
        next_cycle();
        rst_n = 1'b0;
        expect_sig("abort.c7.busy", S_BUSY, 0);
        expect_sig("abort.c7.cnt", S_CNT, 0);
        expect_ctrl("abort.c7", 1'b1, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        for (int unsigned i = 8; i <= 40; i++) begin
            if (i > 8) next_cycle();
            expect_sig($sformatf("abort.c%0d.busy", i), S_BUSY, 0);
            expect_sig($sformatf("abort.c%0d.done", i), S_DONE, 0);
        end

        // Counter saturation on the 4-bit instance.
        do_reset("pre_sat");
        for (int unsigned i = 0; i < 20; i++) begin
            next_cycle();
            drive(1, 0, 0, 0, 0, 0);
            expect_sig($sformatf("sat.c%0d.cnt4", i), S_CNT4, (i > 15) ? 15 : i);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        expect_sig("sat.final.cnt4", S_CNT4, 15);
        expect_sig("sat.final.cnt16", S_CNT, 20);
        expect_ctrl("sat.final", 1'b0, 1'b0);

        next_cycle();
        next_cycle();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Combines three stall sources into a single set of pipeline-control signals: the load-use hazard flag, a multi-cycle HI/LO multiply/divide unit it sequences itself, and ID-stage branch resolution.
- Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX control-bubble mux select.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, EX-side busy cycles for a mult/multu (1..63)
DIV_CYCLES, 32, EX-side busy cycles for a div/divu (1..63)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
lw_hazard  in  1  load-use hazard detected (ID_EX_MemRead and RegRt match), combinational from hazard unit
md_start  in  1  mult/div instruction is in EX this cycle (already past any bubble)
md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
id_md_op  in  1  ID holds a mult/div instruction
id_reads_hilo  in  1  ID holds mfhi/mflo
branch_taken  in  1  ID-stage branch/jump resolved taken
PCWrite  out  1  PC register write enable
IF_ID_Write  out  1  IF/ID register write enable
IF_ID_Flush  out  1  IF/ID register clears to nop at next edge
Mux_Select_Stall  out  1  forces ID/EX control fields to 0 (bubble)
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse on last busy cycle (HI/LO write cycle)
stall_cycles  out  CNT_W  count of cycles with stall asserted

Behaviour:
- Clocking: one clock `clk`. Reset `rst_n` is asynchronous, active-low. All state is cleared immediately when `rst_n` goes low.
- Reset values:
  - md_cnt=0, stall_cycles=0, md_busy=0, md_done=0.
  - While rst_n=0 the outputs are forced to PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1, IF_ID_Flush=0.
- State: 6-bit down-counter md_cnt. Two-state view: IDLE (md_cnt==0) and BUSY (md_cnt!=0).
- IDLE -> BUSY:
  - Trigger: md_start=1 at edge T.
  - Load: md_cnt loads DIV_CYCLES if md_is_div, else MULT_CYCLES.
- BUSY behaviour:
  - md_cnt decrements by 1 each edge.
  - md_busy = (md_cnt!=0), i.e. high for cycles T+1..T+N.
  - md_done = (md_cnt==1), i.e. high in cycle T+N only.
  - BUSY -> IDLE when md_cnt reaches 0.
- md_start while BUSY: ignored. The counter is not reloaded, and nothing faults. ID stalling makes this unreachable in legal code.
- Stall equation (combinational, same cycle): stall = lw_hazard | (md_busy & id_reads_hilo) | (md_busy & id_md_op).
  - The md_done cycle still stalls; release is at T+N+1.
  - HI/LO forwarding is not required.
- Outputs from stall:
  - When stall=1: PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1.
  - When stall=0: PCWrite=1, IF_ID_Write=1, Mux_Select_Stall=0.
- Flush: IF_ID_Flush = branch_taken & ~stall.
  - A stalled branch is suppressed, because it re-resolves on the following cycle with correct operands.
  - Flush never asserts together with Mux_Select_Stall.
- Performance counter: stall_cycles increments on each edge where stall=1. It saturates at all-ones and does not wrap.
- Reset mid-operation: an in-flight mult/div is abandoned. md_busy drops asynchronously and the counter returns to 0.
- Latency: control outputs are combinational from inputs and registered state, so there are zero cycles from a hazard input to the stall outputs. The state effect of md_start is visible one cycle later.

Test Plan:
- Reset: hold rst_n=0 with lw_hazard=0 and branch_taken=1 -> PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1, IF_ID_Flush=0, stall_cycles=0. After release with no hazards -> PCWrite=1, IF_ID_Write=1, Mux_Select_Stall=0.
- Load-use: pulse lw_hazard for exactly 1 cycle -> exactly 1 cycle of PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1; stall_cycles=1.
- Multiply then mfhi: md_start=1, md_is_div=0 at cycle 0, with id_reads_hilo=1 held from cycle 1 -> md_busy in cycles 1-4, md_done in cycle 4, stall in cycles 1-4, PCWrite=1 in cycle 5; stall_cycles=4.
- Divide, back-to-back mult/div, and md_start while busy:
  - Divide at cycle 0, id_md_op=1 held -> stall in cycles 1-32, md_done in cycle 32.
  - md_start re-pulsed at cycle 10 -> md_done still in cycle 32, not 42.
- Branch vs stall:
  - branch_taken=1 with lw_hazard=1 -> IF_ID_Flush=0, Mux_Select_Stall=1.
  - Next cycle, branch_taken=1 with lw_hazard=0 -> IF_ID_Flush=1, PCWrite=1.
- Reset mid-divide and counter saturation:
  - Assert rst_n=0 at busy cycle 7 -> md_busy=0 immediately; after release, no md_done appears.
  - With CNT_W=4, hold lw_hazard for 20 cycles -> stall_cycles stops at 15.
